// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the multi-port register file and its clear sequencer.
`default_nettype none

package reg_file_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_t;

  localparam int DW_DEF = 8;
  localparam int PW_DEF = 4;
endpackage

`default_nettype wire

// File: rtl/reg_clr_seq.sv
// Clear sequencer: walks one entry per cycle from 0 to 2**PW-1 after a clr_req pulse.
`default_nettype none

module reg_clr_seq
  import reg_file_pkg::*;
#(
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_we,
  output logic [PW-1:0] clr_addr
);

  clr_state_t    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clr_we   = 1'b0;
    clr_addr = ptr_q;
    case (state_q)
      IDLE: begin
        // Requests while sweeping are ignored because only IDLE looks at clr_req.
        if (clr_req) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        clr_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == {PW{1'b1}}) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign clr_busy = (state_q == SWEEP);

endmodule

`default_nettype wire

// File: rtl/reg_file_mp.sv
// Parametrised register file: one write port, NRD combinational read ports, optional
// write-first bypass, optional hardwired-zero R0, per-entry written flags, sequenced clear.
`default_nettype none

module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int PW      = PW_DEF,
  parameter int NRD     = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [PW-1:0]           wr_addr,
  input  logic [DW-1:0]           dat_in,
  output logic                    wr_ready,
  input  logic [NRD-1:0][PW-1:0]  rd_addr,
  output logic [NRD-1:0][DW-1:0]  dat_out,
  output logic [NRD-1:0]          rd_valid,
  input  logic                    clr_req,
  output logic                    clr_busy
);

  localparam int DEPTH = 1 << PW;

  logic [DW-1:0]    core_q [DEPTH];
  logic [DW-1:0]    core_d [DEPTH];
  logic [DEPTH-1:0] written_q, written_d;

  logic          clr_we;
  logic [PW-1:0] clr_addr;
  logic          wr_do;

  reg_clr_seq #(
    .PW (PW)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_ready = !clr_busy;

  // A write that actually lands; R0 writes vanish when R0 is hardwired.
  assign wr_do = wr_en && wr_ready && !((ZERO_R0 != 0) && (wr_addr == '0));

  always_comb begin
    core_d    = core_q;
    written_d = written_q;
    if (clr_we) begin
      core_d[clr_addr]    = '0;
      written_d[clr_addr] = 1'b0;
    end else if (wr_do) begin
      core_d[wr_addr]    = dat_in;
      written_d[wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        core_q[i] <= '0;
      end
      written_q <= '0;
    end else begin
      core_q    <= core_d;
      written_q <= written_d;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic rd_zero;
    logic rd_hit;

    assign rd_zero = (ZERO_R0 != 0) && (rd_addr[g] == '0);
    assign rd_hit  = (BYPASS != 0) && wr_do && (wr_addr == rd_addr[g]);

    assign dat_out[g]  = rd_zero ? '0   : rd_hit ? dat_in : core_q[rd_addr[g]];
    assign rd_valid[g] = rd_zero ? 1'b1 : rd_hit ? 1'b1   : written_q[rd_addr[g]];
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (bypass/normal-R0 and no-bypass/zero-R0) share stimulus
// and are compared every cycle against an array-based reference model.
`default_nettype none

module tb_reg_file_mp;
  localparam int DW    = 8;
  localparam int PW    = 4;
  localparam int NRD   = 2;
  localparam int DEPTH = 16;

  logic                   clk;
  logic                   rst_n;
  logic                   wr_en;
  logic [PW-1:0]          wr_addr;
  logic [DW-1:0]          dat_in;
  logic                   clr_req;
  logic [NRD-1:0][PW-1:0] rd_addr;

  logic                   a_wr_ready, a_clr_busy, b_wr_ready, b_clr_busy;
  logic [NRD-1:0][DW-1:0] a_dat_out, b_dat_out;
  logic [NRD-1:0]         a_rd_valid, b_rd_valid;

  reg_file_mp #(.DW(DW), .PW(PW), .NRD(NRD), .BYPASS(1), .ZERO_R0(0)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .wr_ready(a_wr_ready), .rd_addr(rd_addr), .dat_out(a_dat_out), .rd_valid(a_rd_valid),
    .clr_req(clr_req), .clr_busy(a_clr_busy)
  );

  reg_file_mp #(.DW(DW), .PW(PW), .NRD(NRD), .BYPASS(0), .ZERO_R0(1)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .wr_ready(b_wr_ready), .rd_addr(rd_addr), .dat_out(b_dat_out), .rd_valid(b_rd_valid),
    .clr_req(clr_req), .clr_busy(b_clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: instance 0 = bypass, normal R0; instance 1 = no bypass, zero R0.
  logic [DW-1:0] m_core [2][DEPTH];
  bit            m_wr   [2][DEPTH];
  bit            m_sweep;
  int            m_idx;

  int checks   = 0;
  int failures = 0;
  int busy_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int e = 0; e < DEPTH; e++) begin
        m_core[k][e] = '0;
        m_wr[k][e]   = 1'b0;
      end
    end
    m_sweep = 1'b0;
    m_idx   = 0;
  endtask

  task automatic model_clock();
    if (!rst_n) return;
    if (m_sweep) begin
      for (int k = 0; k < 2; k++) begin
        m_core[k][m_idx] = '0;
        m_wr[k][m_idx]   = 1'b0;
      end
      m_idx++;
      if (m_idx == DEPTH) begin
        m_sweep = 1'b0;
        m_idx   = 0;
      end
    end else begin
      if (wr_en) begin
        m_core[0][wr_addr] = dat_in;
        m_wr[0][wr_addr]   = 1'b1;
        if (wr_addr != 0) begin
          m_core[1][wr_addr] = dat_in;
          m_wr[1][wr_addr]   = 1'b1;
        end
      end
      if (clr_req) begin
        m_sweep = 1'b1;
        m_idx   = 0;
      end
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      logic [NRD-1:0][DW-1:0] gd;
      logic [NRD-1:0]         gv;
      logic                   gr, gb;
      gd = (k == 0) ? a_dat_out  : b_dat_out;
      gv = (k == 0) ? a_rd_valid : b_rd_valid;
      gr = (k == 0) ? a_wr_ready : b_wr_ready;
      gb = (k == 0) ? a_clr_busy : b_clr_busy;
      check($sformatf("i%0d_wr_ready", k), 32'(gr), 32'(!m_sweep));
      check($sformatf("i%0d_clr_busy", k), 32'(gb), 32'(m_sweep));
      for (int p = 0; p < NRD; p++) begin
        logic [DW-1:0] ed;
        logic          ev;
        int            ad;
        ad = int'(rd_addr[p]);
        if (k == 1 && ad == 0) begin
          ed = '0; ev = 1'b1;
        end else if (k == 0 && wr_en && !m_sweep && int'(wr_addr) == ad) begin
          ed = dat_in; ev = 1'b1;
        end else begin
          ed = m_core[k][ad]; ev = m_wr[k][ad];
        end
        check($sformatf("i%0d_p%0d_a%0d_dat", k, p, ad), 32'(gd[p]), 32'(ed));
        check($sformatf("i%0d_p%0d_a%0d_vld", k, p, ad), 32'(gv[p]), 32'(ev));
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    clr_req = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    dat_in  = '0;
    clr_req = 1'b0;
    rd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;

    // Every address on both ports after reset.
    for (int e = 0; e < DEPTH; e++) begin
      rd_addr[0] = PW'(e);
      rd_addr[1] = PW'(DEPTH - 1 - e);
      settle();
      tick();
    end

    // Same-cycle write/read of addr 3.
    wr_en = 1'b1; wr_addr = 4'd3; dat_in = 8'hA5;
    rd_addr[0] = 4'd3; rd_addr[1] = 4'd3;
    settle();
    check("byp_a_dat0", 32'(a_dat_out[0]), 32'hA5);
    check("byp_a_dat1", 32'(a_dat_out[1]), 32'hA5);
    check("byp_a_vld",  32'(a_rd_valid), 32'b11);
    check("nobyp_b_dat0", 32'(b_dat_out[0]), 32'h00);
    tick();
    idle();
    settle();
    check("nobyp_b_next", 32'(b_dat_out[0]), 32'hA5);
    tick();

    // Fill with i+1, then sweep.
    for (int e = 0; e < DEPTH; e++) begin
      wr_en = 1'b1; wr_addr = PW'(e); dat_in = DW'(e + 1);
      rd_addr[0] = PW'(e); rd_addr[1] = PW'((e + 5) % DEPTH);
      settle();
      tick();
    end
    idle();
    clr_req = 1'b1;
    rd_addr[0] = 4'd2; rd_addr[1] = 4'd10;
    settle();
    tick();
    clr_req = 1'b0;
    busy_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (n == 5) begin
        rd_addr[0] = 4'd2; rd_addr[1] = 4'd10;
      end
      if (n == 6) begin
        wr_en = 1'b1; wr_addr = 4'd7; dat_in = 8'h3C;
        rd_addr[0] = 4'd7;
      end
      clr_req = (n == 8);
      settle();
      if (n == 5) begin
        check("mid_a2_dat",  32'(a_dat_out[0]), 32'h00);
        check("mid_a2_vld",  32'(a_rd_valid[0]), 32'h0);
        check("mid_a10_dat", 32'(a_dat_out[1]), 32'h0B);
        check("mid_a10_vld", 32'(a_rd_valid[1]), 32'h1);
      end
      if (n == 6) begin
        check("sweep_wr_ready", 32'(a_wr_ready), 32'h0);
        check("sweep_no_byp",   32'(a_dat_out[0]), 32'h08);
      end
      if (!a_clr_busy) begin
        tick();
        break;
      end
      busy_cnt++;
      tick();
    end
    check("busy_cycles", 32'(busy_cnt), 32'd16);
    idle();
    rd_addr[0] = 4'd7; rd_addr[1] = 4'd6;
    settle();
    check("retry_a7_dat", 32'(a_dat_out[0]), 32'h3C);
    check("retry_a7_vld", 32'(a_rd_valid[0]), 32'h1);
    check("post_a6_dat",  32'(a_dat_out[1]), 32'h00);
    tick();
    for (int e = 0; e < DEPTH; e++) begin
      rd_addr[0] = PW'(e); rd_addr[1] = PW'(e);
      settle();
      tick();
    end

    // Write to R0 in the same cycle as clr_req.
    wr_en = 1'b1; wr_addr = 4'd0; dat_in = 8'h55; clr_req = 1'b1;
    rd_addr[0] = 4'd0; rd_addr[1] = 4'd0;
    settle();
    tick();
    idle();
    settle();
    check("r0_a_held", 32'(a_dat_out[0]), 32'h55);
    check("r0_b_zero", 32'(b_dat_out[0]), 32'h00);
    check("r0_b_vld",  32'(b_rd_valid[0]), 32'h1);
    tick();
    settle();
    check("r0_a_swept", 32'(a_dat_out[0]), 32'h00);
    check("r0_a_vld",   32'(a_rd_valid[0]), 32'h0);
    tick();
    repeat (4) begin
      settle();
      tick();
    end

    // Asynchronous reset in the middle of the sweep.
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_a_busy",  32'(a_clr_busy), 32'h0);
    check("arst_b_busy",  32'(b_clr_busy), 32'h0);
    check("arst_a_ready", 32'(a_wr_ready), 32'h1);
    for (int e = 0; e < DEPTH; e++) begin
      rd_addr[0] = PW'(e); rd_addr[1] = PW'(e);
      #1;
      check($sformatf("arst_a%0d_dat", e), 32'(a_dat_out[0]), 32'h0);
      check($sformatf("arst_a%0d_vld", e), 32'(a_rd_valid[0]), 32'h0);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    wr_en = 1'b1; wr_addr = 4'd9; dat_in = 8'h99;
    rd_addr[0] = 4'd9; rd_addr[1] = 4'd0;
    settle();
    tick();
    idle();
    settle();
    check("recov_a9", 32'(a_dat_out[0]), 32'h99);
    tick();

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_addr = PW'($urandom_range(0, DEPTH - 1));
      dat_in  = DW'($urandom);
      clr_req = ($urandom_range(0, 39) == 0);
      for (int p = 0; p < NRD; p++) begin
        rd_addr[p] = ($urandom_range(0, 3) == 0) ? wr_addr : PW'($urandom_range(0, DEPTH - 1));
      end
      settle();
      tick();
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
